// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller: data width, opcode
// constants, FSM state encoding and the buffered command record.
// Used by alu_cmd_fifo and alu_issue_ctrl.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // One buffered command: operation plus both operands.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  // True for the opcodes the ALU actually implements.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO holding cmd_t records (op, A, B).
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   push_i       write wdata_i (ignored while full)
//   pop_i        advance the read pointer (ignored while empty)
//   wdata_i      command to store
//   rdata_o      command at the head (valid while not empty)
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  cmd_t        wdata_i,
  output cmd_t        rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the write even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset; only entries behind a valid pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue stage for the 8-bit tri-state ALU. Commands are buffered in
// alu_cmd_fifo, issued to the ALU one at a time with alu_en high for exactly
// one cycle, and the captured result is offered on a valid/ready port.
//
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   cmd_valid, cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b          command payload
//   alu_a, alu_b, alu_op          registered ALU operands/operation
//   alu_en                        ALU output enable, high only in DRIVE
//   alu_out                       ALU result (Z while alu_en is low)
//   rsp_valid, rsp_ready          response handshake
//   rsp_data                      captured result
//   rsp_err                       illegal-op flag (ALU_ISSUE_ILLEGAL_CHK_EN only)
//   busy                          FSM not idle or commands still buffered
//
// Build option: define ALU_ISSUE_ILLEGAL_CHK_EN to reject unimplemented
// opcodes without driving the ALU and flag them on rsp_err.
//
// State | meaning
// IDLE  | waiting for a buffered command; pops head when FIFO non-empty
// DRIVE | alu_en high for one cycle; result captured at the closing edge
// RESP  | rsp_valid high, rsp_data held until rsp_ready
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  state_e            state_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
  logic              rsp_err_q;
`endif

  cmd_t        push_cmd;
  cmd_t        head_cmd;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        push;
  logic        pop;

  assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // The head is consumed at the same edge IDLE leaves for DRIVE (or RESP).
  assign pop       = (state_q == IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_cmd),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
            // Unimplemented op: answer directly, leave the ALU bus untouched.
            if (!op_is_legal(head_cmd.op)) begin
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else
`endif
            begin
              alu_a_q  <= head_cmd.a;
              alu_b_q  <= head_cmd.b;
              alu_op_q <= head_cmd.op;
              state_q  <= DRIVE;
            end
          end
        end

        DRIVE: begin
          rsp_data_q  <= alu_out;
          rsp_valid_q <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
          rsp_err_q   <= 1'b0;
`endif
          state_q     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Enable is decoded from state so the ALU drives the bus only in DRIVE.
  assign alu_en    = (state_q == DRIVE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
  assign rsp_err   = rsp_err_q;
`endif
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_en;
  wire  [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
  logic       rsp_err;
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  always #5 clk = ~clk;

  // Behavioural tri-state ALU
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return 8'(a + b);
      3'b001:  return 8'(a - b);
      3'b011:  return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_en ? alu_f(alu_op, alu_a, alu_b) : 8'hzz;

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_en    (alu_en),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_exp = 0;
  int n_rsp = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_gap = 0;
  int last_en_cyc = -100;
  logic [8:0] sb[$];   // {err, data}

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_data, input logic exp_err, input bit track);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    while (!cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      if (track) begin
        sb.push_back({exp_err, exp_data});
        n_exp++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_alu_en"}, int'(alu_en), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_alu_a"}, int'(alu_a), 0);
    check({tag, "_alu_b"}, int'(alu_b), 0);
    check({tag, "_alu_op"}, int'(alu_op), 0);
    check({tag, "_rsp_data"}, int'(rsp_data), 0);
  endtask

  // Monitor: response scoreboard, alu_en pulse width/spacing, rsp_data hold.
  initial begin
    logic       prev_en = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] held = 8'h00;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_en) check("en_width", int'(alu_en), 0);
      if (alu_en && !prev_en) begin
        en_cnt++;
        en_gap = cyc - last_en_cyc;
        last_en_cyc = cyc;
      end
      prev_en = alu_en;
      if (hold && rsp_valid) check("rsp_hold", int'(rsp_data), int'(held));
      hold = rsp_valid && !rsp_ready;
      held = rsp_data;
      if (rst_n && rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got data %0d, expected no response", rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_data", int'(rsp_data), int'(e[7:0]));
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
          check("rsp_err", int'(rsp_err), int'(e[8]));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD: 200+100 = 44 mod 256, check cycle-exact latency
    send(3'b000, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1);
    check("t2_en_push_edge", int'(alu_en), 0);
    @(posedge clk); #1;
    check("t2_en_drive", int'(alu_en), 1);
    check("t2_alu_a", int'(alu_a), 200);
    check("t2_alu_b", int'(alu_b), 100);
    check("t2_alu_op", int'(alu_op), 0);
    @(posedge clk); #1;
    check("t2_en_after", int'(alu_en), 0);
    check("t2_rsp_valid", int'(rsp_valid), 1);
    check("t2_rsp_data", int'(rsp_data), 44);
    wait_drain(50);

    // Back-to-back SUB / NOT: 5-10 = 251, ~0x0F = 0xF0
    send(3'b001, 8'd5, 8'd10, 8'd251, 1'b0, 1'b1);
    send(3'b011, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b1);
    wait_drain(50);
    check("t3_en_gap", en_gap, 3);
    check("t3_alu_op_hold", int'(alu_op), 3);
    check("t3_alu_a_hold", int'(alu_a), 15);

    // Backpressure: 1 in RESP + 4 buffered fills DEPTH=4
    rsp_ready = 1'b0;
    send(3'b000, 8'd1, 8'd2, 8'd3, 1'b0, 1'b1);
    send(3'b000, 8'd250, 8'd10, 8'd4, 1'b0, 1'b1);
    send(3'b001, 8'd0, 8'd1, 8'd255, 1'b0, 1'b1);
    send(3'b011, 8'hAA, 8'h00, 8'h55, 1'b0, 1'b1);
    send(3'b000, 8'd128, 8'd128, 8'd0, 1'b0, 1'b1);
    check("t4_cmd_ready_full", int'(cmd_ready), 0);
    check("t4_busy", int'(busy), 1);
    check("t4_rsp_valid", int'(rsp_valid), 1);
    check("t4_rsp_data", int'(rsp_data), 3);
    // Offer a command while full: must not be accepted
    cmd_valid = 1'b1;
    cmd_op = 3'b000;
    cmd_a = 8'd99;
    cmd_b = 8'd99;
    repeat (3) begin
      @(posedge clk); #1;
      check("t4_cmd_ready_hold", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain(100);
    check("t4_rsp_count", n_rsp, n_exp);

    // Unimplemented opcode 010
    e0 = en_cnt;
    send(3'b010, 8'd7, 8'd3, 8'd0, (CHK_EN != 0), 1'b1);
    wait_drain(50);
    check("t5_en_pulses", en_cnt - e0, (CHK_EN != 0) ? 0 : 1);

    // Reset in DRIVE with two commands still queued
    rsp_ready = 1'b0;
    send(3'b000, 8'd1, 8'd1, 8'd2, 1'b0, 1'b1);
    send(3'b000, 8'd9, 8'd9, 8'd18, 1'b0, 1'b0);
    send(3'b001, 8'd9, 8'd1, 8'd8, 1'b0, 1'b0);
    send(3'b011, 8'd0, 8'd0, 8'hFF, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_in_drive", int'(alu_en), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_busy_after", int'(busy), 0);
    check("t6_rsp_valid_after", int'(rsp_valid), 0);
    check("t6_rsp_count", n_rsp, n_exp);
    check("t6_sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
